jtag_tap_ctrl: RTL and testbench



---
 rtl/jtag_pkg.sv | 35 +++
 rtl/jtag_tap_fsm.sv | 66 ++++++
 rtl/jtag_tap_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, instruction codes and the IR
// capture pattern used by the TAP controller and its FSM.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  localparam logic [3:0] IR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_IDCODE  = 4'b0010;
  localparam logic [3:0] IR_USER    = 4'b1000;
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine. Advances once per cycle in which tck_en_i is
// high; srst_i forces Test-Logic-Reset regardless of tck_en_i. next_o exposes
// the state being entered so the datapath can act on transitions.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       internal_clk,
  input  logic       reset_n,
  input  logic       srst_i,
  input  logic       tck_en_i,
  input  logic       tms_i,
  output logic [3:0] state_o,
  output logic [3:0] next_o
);

  tap_state_e state_q, state_d, step_s;

  // Transition taken on one TCK edge for the current TMS value
  always_comb begin
    step_s = TEST_LOGIC_RESET;
    case (state_q)
      TEST_LOGIC_RESET: step_s = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    step_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   step_s = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       step_s = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         step_s = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         step_s = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         step_s = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         step_s = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        step_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   step_s = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       step_s = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         step_s = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         step_s = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         step_s = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         step_s = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        step_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          step_s = TEST_LOGIC_RESET;
    endcase
  end

  // Move only on a TCK edge; the soft reset overrides everything
  always_comb begin
    state_d = state_q;
    if (srst_i) begin
      state_d = TEST_LOGIC_RESET;
    end else if (tck_en_i) begin
      state_d = step_s;
    end else begin
      state_d = state_q;
    end
  end

  // State register
  always_ff @(posedge internal_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller in the internal_clk domain. TMS/TDI are synchronised,
// the FSM steps on each tck_en pulse, and the top holds the IR, the IDCODE,
// BYPASS and USER data registers plus registered TDO.
// Build option JTAG_TAP_TRST_EN adds the trst_n input (synchronised, forces
// Test-Logic-Reset and IDCODE while low, leaves user_data alone).
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_W        = 4,
  parameter int          USER_W      = 8,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              internal_clk,
  input  logic              reset_n,
`ifdef JTAG_TAP_TRST_EN
  input  logic              trst_n,
`endif
  input  logic              tck_en,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_value,
  input  logic [USER_W-1:0] user_capture,
  output logic [USER_W-1:0] user_data,
  output logic              user_update
);

  localparam logic [IR_W-1:0] IR_BYP_W = '1;
  localparam logic [IR_W-1:0] IR_IDC_W = IR_W'(IR_IDCODE);
  localparam logic [IR_W-1:0] IR_USR_W = IR_W'(IR_USER);
  localparam logic [IR_W-1:0] IR_CAP_W = IR_W'(IR_CAPTURE);

  function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
    if (ir == IR_BYP_W) begin
      return SEL_BYPASS;
    end else if (ir == IR_IDC_W) begin
      return SEL_IDCODE;
    end else if (ir == IR_USR_W) begin
      return SEL_USER;
    end else begin
      return SEL_BYPASS;
    end
  endfunction

  logic [SYNC_STAGES-1:0] tms_sync_q, tdi_sync_q;
  logic                   tms_s, tdi_s, srst_s;
  logic [3:0]             state_raw_s, next_raw_s;
  tap_state_e             state_s, next_s;
  dr_sel_e                sel_s;

  logic [IR_W-1:0]   ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic              byp_q, byp_d;
  logic [USER_W-1:0] usr_sr_q, usr_sr_d, user_data_q, user_data_d;
  logic              user_update_q, user_update_d;
  logic              tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;

  // Pin synchronisers for TMS and TDI
  always_ff @(posedge internal_clk or negedge reset_n) begin
    if (!reset_n) begin
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
    end else begin
      tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
    end
  end

  assign tms_s = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s = tdi_sync_q[SYNC_STAGES-1];

`ifdef JTAG_TAP_TRST_EN
  logic [1:0] trst_sync_q;

  // Two-flop synchroniser for the optional test reset pin
  always_ff @(posedge internal_clk or negedge reset_n) begin
    if (!reset_n) begin
      trst_sync_q <= 2'b00;
    end else begin
      trst_sync_q <= {trst_sync_q[0], trst_n};
    end
  end

  assign srst_s = ~trst_sync_q[1];
`else
  assign srst_s = 1'b0;
`endif

  jtag_tap_fsm u_fsm (
    .internal_clk (internal_clk),
    .reset_n      (reset_n),
    .srst_i       (srst_s),
    .tck_en_i     (tck_en),
    .tms_i        (tms_s),
    .state_o      (state_raw_s),
    .next_o       (next_raw_s)
  );

  assign state_s = tap_state_e'(state_raw_s);
  assign next_s  = tap_state_e'(next_raw_s);
  assign sel_s   = decode_ir(ir_q);

  // Capture/shift on the edge leaving those states, update on entering Update
  always_comb begin
    ir_sr_d       = ir_sr_q;
    ir_d          = ir_q;
    id_sr_d       = id_sr_q;
    byp_d         = byp_q;
    usr_sr_d      = usr_sr_q;
    user_data_d   = user_data_q;
    user_update_d = 1'b0;
    tdo_d         = 1'b0;
    tdo_oe_d      = 1'b0;

    if (tck_en) begin
      case (state_s)
        CAPTURE_IR: ir_sr_d = IR_CAP_W;
        SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_W-1:1]};
        CAPTURE_DR: begin
          case (sel_s)
            SEL_IDCODE: id_sr_d  = IDCODE_VAL;
            SEL_USER:   usr_sr_d = user_capture;
            default:    byp_d    = 1'b0;
          endcase
        end
        SHIFT_DR: begin
          case (sel_s)
            SEL_IDCODE: id_sr_d  = {tdi_s, id_sr_q[31:1]};
            SEL_USER:   usr_sr_d = (usr_sr_q >> 1'b1) | (USER_W'(tdi_s) << (USER_W - 1));
            default:    byp_d    = tdi_s;
          endcase
        end
        default: begin
        end
      endcase
    end else begin
      ir_sr_d = ir_sr_q;
    end

    // Any entry into (or stay in) Test-Logic-Reset reselects IDCODE
    if (next_s == TEST_LOGIC_RESET) begin
      ir_d = IR_IDC_W;
    end else if (tck_en && (next_s == UPDATE_IR)) begin
      ir_d = ir_sr_q;
    end else begin
      ir_d = ir_q;
    end

    if (tck_en && (next_s == UPDATE_DR) && (sel_s == SEL_USER)) begin
      user_data_d   = usr_sr_q;
      user_update_d = 1'b1;
    end else begin
      user_update_d = 1'b0;
    end

    // TDO follows the LSB of whichever register is shifting
    case (state_s)
      SHIFT_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
      end
      SHIFT_DR: begin
        tdo_oe_d = 1'b1;
        case (sel_s)
          SEL_IDCODE: tdo_d = id_sr_q[0];
          SEL_USER:   tdo_d = usr_sr_q[0];
          default:    tdo_d = byp_q;
        endcase
      end
      default: begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge internal_clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_sr_q       <= '0;
      ir_q          <= IR_IDC_W;
      id_sr_q       <= 32'h0000_0000;
      byp_q         <= 1'b0;
      usr_sr_q      <= '0;
      user_data_q   <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      ir_sr_q       <= ir_sr_d;
      ir_q          <= ir_d;
      id_sr_q       <= id_sr_d;
      byp_q         <= byp_d;
      usr_sr_q      <= usr_sr_d;
      user_data_q   <= user_data_d;
      user_update_q <= user_update_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
    end
  end

  assign tap_state   = state_raw_s;
  assign ir_value    = ir_q;
  assign user_data   = user_data_q;
  assign user_update = user_update_q;
  assign tdo         = tdo_q;
  assign tdo_oe      = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: a directed vector table, hand-written
// scan sequences and random TMS/TDI traffic compared with a queue-based model.
module tb_jtag_tap_ctrl;

  localparam int S_E2D = 0,  S_E1D = 1,  S_SDR = 2,  S_PDR = 3;
  localparam int S_SIS = 4,  S_UDR = 5,  S_CDR = 6,  S_SDS = 7;
  localparam int S_E2I = 8,  S_E1I = 9,  S_SIR = 10, S_PIR = 11;
  localparam int S_RTI = 12, S_UIR = 13, S_CIR = 14, S_TLR = 15;
  localparam logic [31:0] IDC = 32'h1000_0001;

  logic       internal_clk = 1'b0;
  logic       reset_n, tck_en, tms, tdi;
  logic       tdo, tdo_oe, user_update;
  logic [3:0] tap_state, ir_value;
  logic [7:0] user_capture, user_data;

  jtag_tap_ctrl #(
    .IR_W(4), .USER_W(8), .IDCODE_VAL(32'h1000_0001), .SYNC_STAGES(2)
  ) dut (
    .internal_clk (internal_clk),
    .reset_n      (reset_n),
`ifdef JTAG_TAP_TRST_EN
    .trst_n       (1'b1),
`endif
    .tck_en       (tck_en),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .tdo_oe       (tdo_oe),
    .tap_state    (tap_state),
    .ir_value     (ir_value),
    .user_capture (user_capture),
    .user_data    (user_data),
    .user_update  (user_update)
  );

  always #5 internal_clk = ~internal_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_seen = 0;

  // ---------------- reference model ----------------
  int         nxt0[16], nxt1[16];
  int         m_state;
  logic [3:0] m_ir;
  logic [7:0] m_udata;
  bit         m_upd;
  bit         m_irq[$];
  bit         m_drq[$];

  function automatic void tr(input int s, input int on0, input int on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endfunction

  function automatic void init_tbl();
    tr(S_TLR, S_RTI, S_TLR); tr(S_RTI, S_RTI, S_SDS);
    tr(S_SDS, S_CDR, S_SIS); tr(S_CDR, S_SDR, S_E1D);
    tr(S_SDR, S_SDR, S_E1D); tr(S_E1D, S_PDR, S_UDR);
    tr(S_PDR, S_PDR, S_E2D); tr(S_E2D, S_SDR, S_UDR);
    tr(S_UDR, S_RTI, S_SDS); tr(S_SIS, S_CIR, S_TLR);
    tr(S_CIR, S_SIR, S_E1I); tr(S_SIR, S_SIR, S_E1I);
    tr(S_E1I, S_PIR, S_UIR); tr(S_PIR, S_PIR, S_E2I);
    tr(S_E2I, S_SIR, S_UIR); tr(S_UIR, S_RTI, S_SDS);
  endfunction

  function automatic void load_q(input bit is_ir, input logic [31:0] v, input int w);
    if (is_ir) m_irq.delete(); else m_drq.delete();
    for (int i = 0; i < w; i++) begin
      if (is_ir) m_irq.push_back(v[i]); else m_drq.push_back(v[i]);
    end
  endfunction

  function automatic logic [31:0] q2v(input bit is_ir);
    logic [31:0] v = 32'h0;
    int n = is_ir ? m_irq.size() : m_drq.size();
    for (int i = 0; i < n; i++) v[i] = is_ir ? m_irq[i] : m_drq[i];
    return v;
  endfunction

  function automatic void mdl_reset();
    m_state = S_TLR; m_ir = 4'b0010; m_udata = 8'h00; m_upd = 1'b0;
    load_q(1'b1, 32'h0, 4);
    load_q(1'b0, 32'h0, 1);
  endfunction

  function automatic void mdl_step(input bit m, input bit d);
    int ns = m ? nxt1[m_state] : nxt0[m_state];
    m_upd = 1'b0;
    if (m_state == S_CIR) load_q(1'b1, 32'h1, 4);
    if (m_state == S_SIR) begin void'(m_irq.pop_front()); m_irq.push_back(d); end
    if (m_state == S_CDR) begin
      if (m_ir == 4'b0010)      load_q(1'b0, IDC, 32);
      else if (m_ir == 4'b1000) load_q(1'b0, {24'h0, user_capture}, 8);
      else                      load_q(1'b0, 32'h0, 1);
    end
    if (m_state == S_SDR) begin void'(m_drq.pop_front()); m_drq.push_back(d); end
    if (ns == S_UIR) m_ir = q2v(1'b1);
    if (ns == S_UDR && m_ir == 4'b1000) begin m_udata = q2v(1'b0); m_upd = 1'b1; end
    if (ns == S_TLR) m_ir = 4'b0010;
    m_state = ns;
  endfunction

  function automatic bit m_tdo();
    if (m_state == S_SIR) return m_irq[0];
    if (m_state == S_SDR) return m_drq[0];
    return 1'b0;
  endfunction

  // ---------------- checking and stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One TCK edge: pins set, allowed to settle through the synchroniser,
  // then a single tck_en cycle; outputs checked against the model.
  task automatic tck_pulse(input bit m, input bit d);
    @(negedge internal_clk);
    tms = m; tdi = d;
    repeat (3) @(negedge internal_clk);
    tck_en = 1'b1;
    @(negedge internal_clk);
    tck_en = 1'b0;
    mdl_step(m, d);
    chk("state", {28'h0, tap_state}, m_state);
    chk("ir", {28'h0, ir_value}, {28'h0, m_ir});
    chk("user_data", {24'h0, user_data}, {24'h0, m_udata});
    chk("user_update", {31'h0, user_update}, {31'h0, m_upd});
    if (user_update === 1'b1) upd_seen++;
    @(negedge internal_clk);
    chk("tdo", {31'h0, tdo}, {31'h0, m_tdo()});
    chk("tdo_oe", {31'h0, tdo_oe}, (m_state == S_SIR || m_state == S_SDR) ? 32'h1 : 32'h0);
    chk("user_update_len", {31'h0, user_update}, 32'h0);
    if (user_update === 1'b1) upd_seen++;
  endtask

  task automatic load_ir(input logic [3:0] v);
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_pulse(i == 3, v[i]);
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tck_pulse(i == n - 1, din[i]);
    end
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0);
  endtask

  typedef struct { bit tms; logic [3:0] st; bit oe; } vec_t;
  vec_t vecs[9];

  initial begin
    logic [31:0] rd;
    int          u0;

    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 4'hF, 1'b0};
    vecs[5] = '{1'b0, 4'hC, 1'b0};
    vecs[6] = '{1'b1, 4'h7, 1'b0};
    vecs[7] = '{1'b0, 4'h6, 1'b0};
    vecs[8] = '{1'b0, 4'h2, 1'b1};

    init_tbl();
    reset_n = 1'b0; tck_en = 1'b0; tms = 1'b0; tdi = 1'b0; user_capture = 8'h00;
    repeat (3) @(negedge internal_clk);
    chk("rst_state", {28'h0, tap_state}, 32'hF);
    chk("rst_ir", {28'h0, ir_value}, 32'h2);
    chk("rst_tdo", {30'h0, tdo, tdo_oe}, 32'h0);
    chk("rst_user", {23'h0, user_update, user_data}, 32'h0);
    reset_n = 1'b1;
    mdl_reset();

    // Directed table: TMS reset, then walk into Shift-DR
    for (int i = 0; i < 9; i++) begin
      tck_pulse(vecs[i].tms, 1'b0);
      chk("tbl_state", {28'h0, tap_state}, {28'h0, vecs[i].st});
      chk("tbl_oe", {31'h0, tdo_oe}, {31'h0, vecs[i].oe});
    end

    // IDCODE readout
    for (int i = 0; i < 32; i++) begin
      rd[i] = tdo;
      tck_pulse(i == 31, 1'b0);
    end
    chk("idcode", rd, IDC);
    chk("oe_after_shift", {31'h0, tdo_oe}, 32'h0);
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0);

    // USER write with capture readback
    load_ir(4'b1000);
    chk("ir_user", {28'h0, ir_value}, 32'h8);
    user_capture = 8'h3C;
    u0 = upd_seen;
    shift_dr(8, 32'hA5, rd);
    chk("user_capture_rd", rd, 32'h3C);
    chk("user_data_a5", {24'h0, user_data}, 32'hA5);
    chk("user_update_once", upd_seen - u0, 32'd1);

    // Unknown opcode behaves as BYPASS: one-edge delay
    load_ir(4'b0110);
    shift_dr(4, 32'b1101, rd);
    chk("bypass", rd, 32'b1010);

    // Escape from Shift-DR with five TMS=1 edges
    u0 = upd_seen;
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck_pulse(1'b1, 1'b0);
    chk("escape_4th", {28'h0, tap_state}, 32'h4);
    tck_pulse(1'b1, 1'b0);
    chk("escape_5th", {28'h0, tap_state}, 32'hF);
    chk("escape_no_upd", upd_seen - u0, 32'd0);

    // Asynchronous reset in the middle of Shift-IR
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b1, 1'b0); tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0); tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b1);
    @(negedge internal_clk);
    tck_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", {28'h0, tap_state}, 32'hF);
    chk("mid_rst_ir", {28'h0, ir_value}, 32'h2);
    chk("mid_rst_out", {22'h0, tdo, tdo_oe, user_update, user_data}, 32'h0);
    repeat (3) @(negedge internal_clk);
    chk("mid_rst_hold", {28'h0, tap_state}, 32'hF);
    tck_en = 1'b0;
    reset_n = 1'b1;
    mdl_reset();
    tck_pulse(1'b0, 1'b0);
    tms = 1'b1;
    repeat (3) @(negedge internal_clk);
    tck_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge internal_clk);
      mdl_step(1'b1, tdi);
      chk("held_tck_en", {28'h0, tap_state}, m_state);
    end
    tck_en = 1'b0;
    chk("held_end_tlr", {28'h0, tap_state}, 32'hF);

    // Random traffic against the model
    for (int r = 0; r < 25; r++) begin
      logic [3:0] op;
      int n;
      for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'($urandom));
      tck_pulse(1'b0, 1'b0);
      case ($urandom_range(0, 3))
        0:       op = 4'b1000;
        1:       op = 4'b0010;
        2:       op = 4'b1111;
        default: op = 4'($urandom);
      endcase
      load_ir(op);
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) begin
        user_capture = 8'($urandom);
        tck_pulse($urandom_range(0, 4) < 2, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
